// File: rtl/iterative_limb_multiplier.sv
// Sequential redundant-limb multiplier: accumulates ROWS_PER_CYCLE partial-product rows
// per clock into column accumulators, then carry-normalises one output limb per clock.
module iterative_limb_multiplier #(
    parameter int NUM_ELEMENTS   = 17,
    parameter int BIT_LEN        = 17,
    parameter int WORD_LEN       = 16,
    parameter int ROWS_PER_CYCLE = 1,
    localparam int ACC_LEN       = 2*BIT_LEN + $clog2(NUM_ELEMENTS) + 1,
    localparam int TOP_LEN       = 2*(BIT_LEN-WORD_LEN) + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIT_LEN-1:0]  A [NUM_ELEMENTS],
    input  logic [BIT_LEN-1:0]  B [NUM_ELEMENTS],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_LEN-1:0] M [2*NUM_ELEMENTS],
    output logic [TOP_LEN-1:0]  M_hi
);

    localparam int COLS    = 2*NUM_ELEMENTS;
    localparam int CNT_W   = $clog2(COLS) + 1;
    localparam int T_W     = ACC_LEN + 1;
    localparam int CARRY_W = T_W - WORD_LEN;
    localparam int PROD_W  = 2*BIT_LEN;

    typedef enum logic [1:0] {IDLE, ACCUM, NORM, DONE} state_t;

    state_t              state_q, state_d;
    logic [BIT_LEN-1:0]  a_q [NUM_ELEMENTS];
    logic [BIT_LEN-1:0]  a_d [NUM_ELEMENTS];
    logic [BIT_LEN-1:0]  b_q [NUM_ELEMENTS];
    logic [BIT_LEN-1:0]  b_d [NUM_ELEMENTS];
    logic [ACC_LEN-1:0]  acc_q [COLS];
    logic [ACC_LEN-1:0]  acc_d [COLS];
    logic [CNT_W-1:0]    row_q, row_d;
    logic [CNT_W-1:0]    k_q, k_d;
    logic [CARRY_W-1:0]  c_q, c_d;
    logic [WORD_LEN-1:0] m_q [COLS];
    logic [WORD_LEN-1:0] m_d [COLS];
    logic [TOP_LEN-1:0]  m_hi_q, m_hi_d;

    logic [BIT_LEN-1:0]  a_row [ROWS_PER_CYCLE];
    logic [PROD_W-1:0]   pp [ROWS_PER_CYCLE][NUM_ELEMENTS];
    logic [T_W-1:0]      t;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign M         = m_q;
    assign M_hi      = m_hi_q;

    // Rows past the last limb select zero, so a partial final group adds nothing.
    always_comb begin
        for (int unsigned r = 0; r < ROWS_PER_CYCLE; r++) begin
            a_row[r] = '0;
            for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
                if (32'(row_q) + r == i) a_row[r] = a_q[i];
            end
            for (int unsigned j = 0; j < NUM_ELEMENTS; j++) begin
                pp[r][j] = a_row[r] * b_q[j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        row_d   = row_q;
        k_d     = k_q;
        c_d     = c_q;
        m_d     = m_q;
        m_hi_d  = m_hi_q;
        t       = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = '{default: '0};
                    row_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                for (int unsigned col = 0; col < COLS; col++) begin
                    for (int unsigned r = 0; r < ROWS_PER_CYCLE; r++) begin
                        for (int unsigned j = 0; j < NUM_ELEMENTS; j++) begin
                            if (32'(row_q) + r + j == col)
                                acc_d[col] = acc_d[col] + ACC_LEN'(pp[r][j]);
                        end
                    end
                end
                if (32'(row_q) + ROWS_PER_CYCLE >= NUM_ELEMENTS) begin
                    c_d     = '0;
                    k_d     = '0;
                    state_d = NORM;
                end else begin
                    row_d = row_q + CNT_W'(ROWS_PER_CYCLE);
                end
            end
            NORM: begin
                for (int unsigned col = 0; col < COLS; col++) begin
                    if (k_q == CNT_W'(col)) begin
                        t        = {1'b0, acc_q[col]} + T_W'(c_q);
                        m_d[col] = t[WORD_LEN-1:0];
                    end
                end
                c_d = t[T_W-1:WORD_LEN];
                k_d = k_q + CNT_W'(1);
                if (k_q == CNT_W'(COLS-1)) begin
                    m_hi_d  = c_d[TOP_LEN-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            acc_q   <= '{default: '0};
            row_q   <= '0;
            k_q     <= '0;
            c_q     <= '0;
            m_q     <= '{default: '0};
            m_hi_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            row_q   <= row_d;
            k_q     <= k_d;
            c_q     <= c_d;
            m_q     <= m_d;
            m_hi_q  <= m_hi_d;
        end
    end

endmodule

// File: tb/tb_iterative_limb_multiplier.sv
// Bench for iterative_limb_multiplier: three instances (N=17/R=1, N=2/R=1, N=17/R=4)
// checked against a wide-integer product model through per-instance scoreboards.
module tb_iterative_limb_multiplier;

    localparam int PW = 600;

    typedef logic [16:0] limbs17_t [17];
    typedef logic [16:0] limbs2_t  [2];
    typedef logic [15:0] m34_t     [34];
    typedef logic [15:0] m4_t      [4];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic     iv17, ir17, ov17, or17;
    limbs17_t a17, b17;
    m34_t     m17;
    logic [3:0] mh17;

    logic     iv2, ir2, ov2, or2;
    limbs2_t  a2, b2;
    m4_t      m2;
    logic [3:0] mh2;

    logic     iv4, ir4, ov4, or4;
    limbs17_t a4, b4;
    m34_t     m4;
    logic [3:0] mh4;

    logic [PW-1:0] q17[$];
    logic [PW-1:0] q2[$];
    logic [PW-1:0] q4[$];

    int checks = 0;
    int passes = 0;

    iterative_limb_multiplier #(.NUM_ELEMENTS(17), .BIT_LEN(17), .WORD_LEN(16), .ROWS_PER_CYCLE(1)) dut17 (
        .clk(clk), .rst(rst), .in_valid(iv17), .in_ready(ir17), .A(a17), .B(b17),
        .out_valid(ov17), .out_ready(or17), .M(m17), .M_hi(mh17)
    );

    iterative_limb_multiplier #(.NUM_ELEMENTS(2), .BIT_LEN(17), .WORD_LEN(16), .ROWS_PER_CYCLE(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
        .out_valid(ov2), .out_ready(or2), .M(m2), .M_hi(mh2)
    );

    iterative_limb_multiplier #(.NUM_ELEMENTS(17), .BIT_LEN(17), .WORD_LEN(16), .ROWS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
        .out_valid(ov4), .out_ready(or4), .M(m4), .M_hi(mh4)
    );

    function automatic logic [PW-1:0] val17(input limbs17_t x);
        logic [PW-1:0] v = '0;
        for (int i = 0; i < 17; i++) v = v + (PW'(x[i]) << (16*i));
        return v;
    endfunction

    function automatic logic [PW-1:0] val2(input limbs2_t x);
        logic [PW-1:0] v = '0;
        for (int i = 0; i < 2; i++) v = v + (PW'(x[i]) << (16*i));
        return v;
    endfunction

    function automatic logic [PW-1:0] obs17(input m34_t m, input logic [3:0] hi);
        logic [PW-1:0] v = '0;
        for (int k = 0; k < 34; k++) v[16*k +: 16] = m[k];
        v[544 +: 4] = hi;
        return v;
    endfunction

    function automatic logic [PW-1:0] obs2(input m4_t m, input logic [3:0] hi);
        logic [PW-1:0] v = '0;
        for (int k = 0; k < 4; k++) v[16*k +: 16] = m[k];
        v[64 +: 4] = hi;
        return v;
    endfunction

    function automatic logic [16:0] rnd_limb();
        case ($urandom_range(0, 3))
            0:       return 17'h1FFFF;
            1:       return 17'h00000;
            default: return 17'($urandom);
        endcase
    endfunction

    task automatic start17(input limbs17_t a, input limbs17_t b);
        int n = 0;
        a17 = a; b17 = b; iv17 = 1'b1;
        while (!ir17 && n < 200) begin @(posedge clk); #1; n++; end
        q17.push_back(val17(a) * val17(b));
        @(posedge clk); #1;
        iv17 = 1'b0;
    endtask

    task automatic start2(input limbs2_t a, input limbs2_t b);
        int n = 0;
        a2 = a; b2 = b; iv2 = 1'b1;
        while (!ir2 && n < 200) begin @(posedge clk); #1; n++; end
        q2.push_back(val2(a) * val2(b));
        @(posedge clk); #1;
        iv2 = 1'b0;
    endtask

    task automatic wait_ov17(output int n);
        n = 0;
        while (!ov17 && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait_ov2(output int n);
        n = 0;
        while (!ov2 && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait_ov4(output int n);
        n = 0;
        while (!ov4 && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    task automatic test_reset();
        limbs17_t a, b;
        limbs2_t  c, d;
        int n;
        checks++;
        if (ir17 !== 1'b1) $display("FAIL initial_in_ready: got %b expected 1", ir17);
        else passes++;
        for (int i = 0; i < 17; i++) begin a[i] = rnd_limb(); b[i] = rnd_limb(); end
        c[0] = 17'h1ABCD; c[1] = 17'h0F0F0; d[0] = 17'h12345; d[1] = 17'h1FFFF;
        or17 = 1'b0; or2 = 1'b0;
        start17(a, b);
        start2(c, d);
        wait_ov17(n);
        checks++;
        if (ov17 !== 1'b1) $display("FAIL pre_reset_valid: got %b expected 1", ov17);
        else passes++;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ov17 !== 1'b0 || ov2 !== 1'b0)
            $display("FAIL reset_out_valid: got %b/%b expected 0/0", ov17, ov2);
        else passes++;
        checks++;
        if (obs17(m17, mh17) !== '0) $display("FAIL reset_M17: got %h expected 0", obs17(m17, mh17));
        else passes++;
        checks++;
        if (obs2(m2, mh2) !== '0) $display("FAIL reset_M2: got %h expected 0", obs2(m2, mh2));
        else passes++;
        rst = 1'b0;
        q17.delete();
        q2.delete();
        checks++;
        if (ir17 !== 1'b1 || ir2 !== 1'b1 || ir4 !== 1'b1)
            $display("FAIL post_reset_in_ready: got %b%b%b expected 111", ir17, ir2, ir4);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (ov17 !== 1'b0 || ir17 !== 1'b1)
            $display("FAIL post_reset_idle: got ov=%b ir=%b expected ov=0 ir=1", ov17, ir17);
        else passes++;
    endtask

    task automatic test_basic();
        limbs17_t a, b;
        logic [PW-1:0] exp;
        int n;
        a = '{default: '0}; b = '{default: '0};
        a[0] = 17'd3; b[0] = 17'd5;
        or17 = 1'b1;
        start17(a, b);
        wait_ov17(n);
        checks++;
        if (n !== 51) $display("FAIL basic_latency: got %0d expected 51", n);
        else passes++;
        exp = q17.pop_front();
        checks++;
        if (obs17(m17, mh17) !== exp) $display("FAIL basic_result: got %h expected %h", obs17(m17, mh17), exp);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (ov17 !== 1'b0 || ir17 !== 1'b1)
            $display("FAIL basic_handshake: got ov=%b ir=%b expected ov=0 ir=1", ov17, ir17);
        else passes++;
    endtask

    task automatic test_carry_ripple();
        limbs2_t a, b;
        logic [PW-1:0] exp;
        int n;
        a[0] = 17'h0FFFF; a[1] = 17'h0FFFF; b = a;
        or2 = 1'b1;
        start2(a, b);
        wait_ov2(n);
        checks++;
        if (n !== 6) $display("FAIL ripple_latency: got %0d expected 6", n);
        else passes++;
        exp = q2.pop_front();
        checks++;
        if (obs2(m2, mh2) !== exp) $display("FAIL ripple_result: got %h expected %h", obs2(m2, mh2), exp);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_redundant_max();
        limbs2_t a, b;
        logic [PW-1:0] exp;
        int n;
        a[0] = 17'h1FFFF; a[1] = 17'h1FFFF; b = a;
        or2 = 1'b1;
        start2(a, b);
        wait_ov2(n);
        checks++;
        if (n !== 6) $display("FAIL redmax_latency: got %0d expected 6", n);
        else passes++;
        exp = q2.pop_front();
        checks++;
        if (obs2(m2, mh2) !== exp) $display("FAIL redmax_result: got %h expected %h", obs2(m2, mh2), exp);
        else passes++;
        checks++;
        if (mh2 !== exp[64 +: 4]) $display("FAIL redmax_M_hi: got %h expected %h", mh2, exp[64 +: 4]);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure();
        limbs17_t a, b;
        logic [PW-1:0] exp;
        int n;
        for (int i = 0; i < 17; i++) begin a[i] = rnd_limb(); b[i] = rnd_limb(); end
        or17 = 1'b0;
        start17(a, b);
        wait_ov17(n);
        checks++;
        if (n !== 51) $display("FAIL bp_latency: got %0d expected 51", n);
        else passes++;
        exp = q17[0];
        for (int c = 0; c < 10; c++) begin
            iv17 = (c % 2 == 0);
            for (int i = 0; i < 17; i++) begin a17[i] = rnd_limb(); b17[i] = rnd_limb(); end
            checks++;
            if (ir17 !== 1'b0 || ov17 !== 1'b1)
                $display("FAIL bp_hold_flags: got ir=%b ov=%b expected ir=0 ov=1", ir17, ov17);
            else passes++;
            checks++;
            if (obs17(m17, mh17) !== exp) $display("FAIL bp_hold_M: got %h expected %h", obs17(m17, mh17), exp);
            else passes++;
            @(posedge clk); #1;
        end
        iv17 = 1'b0;
        or17 = 1'b1;
        exp = q17.pop_front();
        checks++;
        if (ov17 !== 1'b1 || obs17(m17, mh17) !== exp)
            $display("FAIL bp_release: got ov=%b M=%h expected ov=1 M=%h", ov17, obs17(m17, mh17), exp);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (ir17 !== 1'b1 || ov17 !== 1'b0)
            $display("FAIL bp_after_handshake: got ir=%b ov=%b expected ir=1 ov=0", ir17, ov17);
        else passes++;
        for (int i = 0; i < 17; i++) begin a[i] = rnd_limb(); b[i] = rnd_limb(); end
        start17(a, b);
        wait_ov17(n);
        exp = q17.pop_front();
        checks++;
        if (obs17(m17, mh17) !== exp) $display("FAIL bp_second_op: got %h expected %h", obs17(m17, mh17), exp);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        limbs17_t a, b;
        logic [PW-1:0] exp;
        int n;
        for (int i = 0; i < 17; i++) begin a[i] = rnd_limb(); b[i] = rnd_limb(); end
        or17 = 1'b1;
        start17(a, b);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q17.delete();
        checks++;
        if (ov17 !== 1'b0 || ir17 !== 1'b1)
            $display("FAIL midreset_idle: got ov=%b ir=%b expected ov=0 ir=1", ov17, ir17);
        else passes++;
        a = '{default: '0}; b = '{default: '0};
        a[16] = 17'h1FFFF; b[16] = 17'h1FFFF;
        start17(a, b);
        wait_ov17(n);
        checks++;
        if (n !== 51) $display("FAIL midreset_latency: got %0d expected 51", n);
        else passes++;
        exp = q17.pop_front();
        checks++;
        if (obs17(m17, mh17) !== exp) $display("FAIL midreset_result: got %h expected %h", obs17(m17, mh17), exp);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_r4_random();
        localparam int NOPS = 1000;
        logic [PW-1:0] exp;
        int n, sent, got, cyc;
        bit acc;
        for (int i = 0; i < 17; i++) begin a4[i] = rnd_limb(); b4[i] = rnd_limb(); end
        or4 = 1'b1; iv4 = 1'b1;
        q4.push_back(val17(a4) * val17(b4));
        @(posedge clk); #1;
        iv4 = 1'b0;
        wait_ov4(n);
        checks++;
        if (n !== 39) $display("FAIL r4_latency: got %0d expected 39", n);
        else passes++;
        exp = q4.pop_front();
        checks++;
        if (obs17(m4, mh4) !== exp) $display("FAIL r4_first: got %h expected %h", obs17(m4, mh4), exp);
        else passes++;
        @(posedge clk); #1;
        sent = 0; got = 0; cyc = 0;
        while (got < NOPS && cyc < 70000) begin
            or4 = ($urandom_range(0, 3) != 0);
            if (sent < NOPS && !iv4 && $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 17; i++) begin a4[i] = rnd_limb(); b4[i] = rnd_limb(); end
                iv4 = 1'b1;
            end
            if (ov4 && or4) begin
                checks++;
                if (q4.size() == 0) begin
                    $display("FAIL r4_unexpected_output: got M=%h expected no result", obs17(m4, mh4));
                end else begin
                    exp = q4.pop_front();
                    if (obs17(m4, mh4) !== exp)
                        $display("FAIL r4_random_%0d: got %h expected %h", got, obs17(m4, mh4), exp);
                    else passes++;
                end
                got++;
            end
            acc = iv4 && ir4;
            if (acc) begin
                q4.push_back(val17(a4) * val17(b4));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) iv4 = 1'b0;
        end
        iv4 = 1'b0;
        checks++;
        if (got !== NOPS) $display("FAIL r4_result_count: got %0d expected %0d", got, NOPS);
        else passes++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        iv17 = 1'b0; or17 = 1'b0; a17 = '{default: '0}; b17 = '{default: '0};
        iv2  = 1'b0; or2  = 1'b0; a2  = '{default: '0}; b2  = '{default: '0};
        iv4  = 1'b0; or4  = 1'b0; a4  = '{default: '0}; b4  = '{default: '0};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_carry_ripple();
        test_redundant_max();
        test_back_pressure();
        test_mid_reset();
        test_r4_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/iterative_limb_multiplier.md
Name: iterative_limb_multiplier

Overview:
- Sequential, area-reduced successor to the combinational limb-array multiplier.
- Multiplies two NUM_ELEMENTS-limb operands in redundant form. Each limb is BIT_LEN bits at radix 2^WORD_LEN.
- Accumulates ROWS_PER_CYCLE partial-product rows per clock into column accumulators, then carry-normalises serially.
- Output is a fully carried, non-redundant product. Sits behind a valid/ready stream in the big-integer datapath.

Parameters:
- NUM_ELEMENTS, 17, limbs per operand (N); >= 2.
- BIT_LEN, 17, input limb width; >= WORD_LEN.
- WORD_LEN, 16, radix bits per limb; output limb width.
- ROWS_PER_CYCLE, 1, partial-product rows accumulated per ACCUM cycle (R); 1..N; need not divide N.
- Derived ACC_LEN, 2*BIT_LEN + $clog2(N) + 1, column accumulator width.
- Derived TOP_LEN, 2*(BIT_LEN-WORD_LEN) + 2, width of M_hi.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- A  in  [BIT_LEN-1:0] x N  multiplicand limbs, value = sum A[i]*2^(WORD_LEN*i)
- B  in  [BIT_LEN-1:0] x N  multiplier limbs, same encoding
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- M  out  [WORD_LEN-1:0] x 2N  normalised product limbs
- M_hi  out  TOP_LEN  product bits at and above 2N*WORD_LEN

Behaviour:
- Reset:
  - One clock; reset synchronous, active-high, on rst.
  - While rst is high at a clock edge: state <= IDLE, out_valid <= 0, M all 0, M_hi <= 0, accumulators <= 0, counters <= 0.
  - in_ready = (state==IDLE), so it reads 1 on the first cycle after reset deasserts.
  - Reset in any state aborts the operation; partial results are discarded and never presented.
- States: IDLE, ACCUM, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register A and B, clear all 2N accumulators, row counter <= 0, go to ACCUM.
- ACCUM:
  - Each edge, for every row i in [row, row+R) with i<N and every j<N: acc[i+j] += A[i]*B[j].
  - Products are 2*BIT_LEN bits, zero-extended to ACC_LEN; no truncation is permitted.
  - row += R. When row+R >= N, go to NORM with carry c <= 0 and k <= 0.
  - ACCUM lasts ceil(N/R) edges. The last group may be partial; out-of-range rows contribute 0.
- NORM, one limb per edge:
  - t = acc[k] + c, computed at ACC_LEN+1 bits.
  - M[k] <= t[WORD_LEN-1:0]; c <= t >> WORD_LEN; k++.
  - After k = 2N-1: M_hi <= final carry[TOP_LEN-1:0], go to DONE. By construction the discarded carry bits are zero.
- DONE:
  - out_valid=1. M and M_hi are held stable; in_ready=0, and in_valid is ignored.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE. in_ready is 1 the next cycle; there is no same-cycle re-accept.
- Latency:
  - L = ceil(N/R) + 2N edges from the accepting edge to the edge that sets out_valid.
  - Default parameters give L = 17 + 34 = 51. Throughput is one result per L+2 cycles minimum.
- Outputs:
  - M and M_hi keep their previous values outside DONE.
  - Outputs are valid only while out_valid=1.
- Arithmetic:
  - M_hi:M equals A*B exactly, as unsigned integers, for all limb values up to 2^BIT_LEN-1.

Test Plan:
- Reset defaults:
  - Assert rst 3 cycles mid-traffic -> out_valid=0, M all 0, M_hi=0.
  - in_ready=1 on the first post-reset cycle.
- Basic operation, defaults:
  - A[0]=3, B[0]=5, all other limbs 0, out_ready=1 -> out_valid rises exactly 51 edges after accept.
  - Expect M[0]=0x000F, all other M=0, M_hi=0.
- Carry ripple, N=2:
  - A={0xFFFF,0xFFFF}, B={0xFFFF,0xFFFF} -> M={0x0001,0x0000,0xFFFE,0xFFFF}, M_hi=0, L=6.
- Redundant max, N=2:
  - All limbs 0x1FFFF -> M={0x0001,0xFFFE,0xFFFC,0x0003}, M_hi=0x4.
- Back-pressure:
  - Hold out_ready=0 for 10 cycles in DONE while toggling in_valid -> M stable, in_ready=0, no capture.
  - Then out_ready=1 -> handshake completes; in_ready=1 next cycle. A second operation gives the correct result.
- Mid-operation reset and R>1:
  - Defaults, reset during ACCUM row 5 -> IDLE; the new op A[16]=B[16]=0x1FFFF gives M[32]=0x0001, M[33]=0xFFFC, M_hi=0x3, all other M=0.
  - With R=4, N=17: latency = 5+34 = 39. Randomised 1000 ops match a big-integer model.
